// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative one-bit-per-cycle shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic             done_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] comb_res;
  logic [SW-1:0]    shamt;

  assign shamt = src_b_i[SW-1:0];

  always_comb begin
    comb_res = '0;
    case (alu_control_i)
      4'h0: comb_res = src_a_i + src_b_i;
      4'h1: comb_res = src_a_i - src_b_i;
      4'h3: comb_res = {{(WIDTH-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
      4'h4: comb_res = {{(WIDTH-1){1'b0}}, src_a_i < src_b_i};
      4'h7: comb_res = src_a_i | src_b_i;
      4'h8: comb_res = src_a_i ^ src_b_i;
      4'h9: comb_res = src_a_i & src_b_i;
`ifdef ALU_FAST_SHIFT_EN
      4'h2: comb_res = src_a_i << shamt;
      4'h5: comb_res = src_a_i >> shamt;
      4'h6: comb_res = $unsigned($signed(src_a_i) >>> shamt);
`else
      // Only reached with a zero shift amount; non-zero amounts go through StShift.
      4'h2, 4'h5, 4'h6: comb_res = src_a_i;
`endif
      default: comb_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN

  assign busy_o = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (start_i) begin
      state_q  <= StDone;
      done_q   <= 1'b1;
      result_q <= comb_res;
      zero_q   <= (comb_res == '0);
    end else begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
    end
  end

`else

  logic             busy_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] step_res;
  logic [SW-1:0]    cnt_q;
  logic             is_shift;

  assign busy_o   = busy_q;
  assign is_shift = (alu_control_i == 4'h2) || (alu_control_i == 4'h5) ||
                    (alu_control_i == 4'h6);

  always_comb begin
    step_res = '0;
    case (op_q)
      4'h2:    step_res = {work_q[WIDTH-2:0], 1'b0};
      4'h5:    step_res = {1'b0, work_q[WIDTH-1:1]};
      default: step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StShift: begin
          work_q <= step_res;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= step_res;
            zero_q   <= (step_res == '0);
          end
        end
        // StIdle and StDone accept identically, giving back-to-back issue from StDone.
        default: begin
          if (start_i) begin
            if (is_shift && (shamt != '0)) begin
              state_q <= StShift;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              op_q    <= alu_control_i;
              work_q  <= src_a_i;
              cnt_q   <= shamt;
            end else begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= comb_res;
              zero_q   <= (comb_res == '0);
            end
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

`endif

  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  alu_control_i = '0;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  int n_checks = 0;
  int n_errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .alu_control_i (alu_control_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .zero_o        (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one rising edge; returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i       = 1'b1;
    alu_control_i = op;
    src_a_i       = a;
    src_b_i       = b;
    @(negedge clk_i);
    start_i       = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(op, a, b);
    lat = 1;
    while (!done_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result_o, exp_res);
    check_eq({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp_res == 32'h0});
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;

    @(negedge clk_i);
    check_eq("rst_busy", {31'b0, busy_o}, 32'h0);
    check_eq("rst_done", {31'b0, done_o}, 32'h0);
    check_eq("rst_result", result_o, 32'h0);
    check_eq("rst_zero", {31'b0, zero_o}, 32'h1);
    rst_i = 1'b0;

    run_op("add", 4'h0, 32'd5, 32'd7, 32'd12, 1);
    @(negedge clk_i);
    check_eq("add_pulse_end", {31'b0, done_o}, 32'h0);
    run_op("sub", 4'h1, 32'd3, 32'd3, 32'd0, 1);
    run_op("sub_wrap", 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    run_op("slt", 4'h3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 4'h4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("code_c", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
    run_op("or", 4'h7, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
    run_op("and", 4'h9, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    run_op("sll0", 4'h2, 32'h0000_00A5, 32'h0000_0020, 32'h0000_00A5, 1);
    run_op("sll_mask", 4'h2, 32'd3, 32'h0000_0025, 32'h0000_0060, Fast ? 1 : 6);

    // SLL by 31: busy for 31 cycles, done 32 cycles after acceptance.
    issue(4'h2, 32'd1, 32'd31);
    lat = 1;
    busy_cnt = 0;
    while (!done_o && lat < 200) begin
      if (busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
    check_eq("sll31_lat", lat, Fast ? 1 : 32);
    check_eq("sll31_busy", busy_cnt, Fast ? 0 : 31);
    check_eq("sll31_res", result_o, 32'h8000_0000);

    // SRA with a start pulse and operand change mid-shift; both must be ignored.
    issue(4'h6, 32'h8000_0000, 32'd4);
    lat = 1;
    while (!done_o && lat < 200) begin
      if (lat == 2) begin
        start_i       = 1'b1;
        alu_control_i = 4'h0;
        src_a_i       = 32'd1;
        src_b_i       = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    check_eq("sra_lat", lat, Fast ? 1 : 5);
    check_eq("sra_res", result_o, 32'hF800_0000);
    @(negedge clk_i);
    check_eq("sra_no_queue", {31'b0, done_o}, 32'h0);

    run_op("srl", 4'h5, 32'h8000_0000, 32'd4, 32'h0800_0000, Fast ? 1 : 5);

    // Asynchronous reset three cycles into a 20-bit shift.
    issue(4'h2, 32'd1, 32'd20);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_busy", {31'b0, busy_o}, 32'h0);
    check_eq("arst_done", {31'b0, done_o}, 32'h0);
    check_eq("arst_result", result_o, 32'h0);
    check_eq("arst_zero", {31'b0, zero_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
    check_eq("arst_no_done", done_cnt, 0);
    run_op("add_after_rst", 4'h0, 32'd2, 32'd2, 32'd4, 1);

    // Back-to-back acceptance from StDone.
    @(negedge clk_i);
    start_i       = 1'b1;
    alu_control_i = 4'h0;
    src_a_i       = 32'd1;
    src_b_i       = 32'd2;
    @(negedge clk_i);
    check_eq("b2b_done1", {31'b0, done_o}, 32'h1);
    check_eq("b2b_res1", result_o, 32'd3);
    alu_control_i = 4'h8;
    src_a_i       = 32'h0000_00F0;
    src_b_i       = 32'h0000_00FF;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("b2b_done2", {31'b0, done_o}, 32'h1);
    check_eq("b2b_res2", result_o, 32'h0000_000F);
    @(negedge clk_i);
    check_eq("b2b_done_end", {31'b0, done_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
